// File: rtl/vscale_htif_pcr_arbiter_pkg.sv
// Shared widths, state encoding and the hold-register layout for the HTIF PCR arbiter.
package vscale_htif_pcr_arbiter_pkg;

    localparam int CSR_ADDR_WIDTH = 12;
    localparam int HTIF_PCR_WIDTH = 64;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                      rw;
        logic [CSR_ADDR_WIDTH-1:0] addr;
        logic [HTIF_PCR_WIDTH-1:0] data;
    } pcr_req_t;

    // (base + step) mod n, valid while base < n and step <= n.
    function automatic int wrap_add(input int base, input int step, input int n);
        int sum;
        sum = base + step;
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/vscale_htif_pcr_arbiter_if.sv
// Requester-side and CSR-side handshake bundle of the HTIF PCR arbiter.
// master: the arbiter itself; slave: the requesters together with the CSR file.
interface vscale_htif_pcr_arbiter_if #(
    parameter int N_REQ = 2
);
    import vscale_htif_pcr_arbiter_pkg::*;

    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ-1:0]                req_ready;
    logic [N_REQ-1:0]                req_rw;
    logic [N_REQ*CSR_ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*HTIF_PCR_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]                resp_valid;
    logic [N_REQ-1:0]                resp_ready;
    logic [HTIF_PCR_WIDTH-1:0]       resp_data;

    logic                            pcr_req_valid;
    logic                            pcr_req_ready;
    logic                            pcr_req_rw;
    logic [CSR_ADDR_WIDTH-1:0]       pcr_req_addr;
    logic [HTIF_PCR_WIDTH-1:0]       pcr_req_data;
    logic                            pcr_resp_valid;
    logic                            pcr_resp_ready;
    logic [HTIF_PCR_WIDTH-1:0]       pcr_resp_data;

    modport master (
        input  req_valid, req_rw, req_addr, req_data, resp_ready,
        input  pcr_req_ready, pcr_resp_valid, pcr_resp_data,
        output req_ready, resp_valid, resp_data,
        output pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data, pcr_resp_ready
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_data, resp_ready,
        output pcr_req_ready, pcr_resp_valid, pcr_resp_data,
        input  req_ready, resp_valid, resp_data,
        input  pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data, pcr_resp_ready
    );

endinterface

// File: rtl/vscale_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or above ptr, wrapping modulo N_REQ.
module vscale_rr_pick
    import vscale_htif_pcr_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    assign any = |valid;

    always_comb begin
        // NOTE: give every combinationally written variable a default first so no path infers a latch.
        idx = '0;
        // Walk from the farthest candidate back toward ptr so the nearest valid one wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (valid[IDX_W'(wrap_add(int'(ptr), k, N_REQ))]) begin
                idx = IDX_W'(wrap_add(int'(ptr), k, N_REQ));
            end
        end
    end

endmodule

// File: rtl/vscale_htif_pcr_arbiter.sv
// Round-robin arbiter sharing the CSR file's single HTIF PCR channel among N_REQ requesters,
// with one transaction in flight: IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE.
module vscale_htif_pcr_arbiter
    import vscale_htif_pcr_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    vscale_htif_pcr_arbiter_if.master bus,
    output logic                      busy
);

    arb_state_t                r_state;
    logic [IDX_W-1:0]          r_owner;
    logic [IDX_W-1:0]          r_rr_ptr;
    pcr_req_t                  r_hold;
    logic [HTIF_PCR_WIDTH-1:0] r_hold_resp;
    logic                      r_pcr_req_valid;
    logic                      r_pcr_resp_ready;
    logic                      r_busy;
    logic [N_REQ-1:0]          r_resp_valid;

    logic                      w_any;
    logic [IDX_W-1:0]          w_grant;
    logic [N_REQ-1:0]          w_grant_oh;
    logic [N_REQ-1:0]          w_owner_oh;
    pcr_req_t                  w_req_sel;

    vscale_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (r_rr_ptr),
        .any   (w_any),
        .idx   (w_grant)
    );

    assign w_grant_oh     = N_REQ'(1) << w_grant;
    assign w_owner_oh     = N_REQ'(1) << r_owner;
    assign w_req_sel.rw   = bus.req_rw[w_grant];
    assign w_req_sel.addr = bus.req_addr[w_grant * CSR_ADDR_WIDTH +: CSR_ADDR_WIDTH];
    assign w_req_sel.data = bus.req_data[w_grant * HTIF_PCR_WIDTH +: HTIF_PCR_WIDTH];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: the hold registers are reset too, since pcr_req_* and resp_data must read zero out of reset.
            r_state          <= S_IDLE;
            r_owner          <= '0;
            r_rr_ptr         <= '0;
            r_hold           <= '0;
            r_hold_resp      <= '0;
            r_pcr_req_valid  <= 1'b0;
            r_pcr_resp_ready <= 1'b1;
            r_busy           <= 1'b0;
            r_resp_valid     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A pcr_resp_valid seen here is stale and simply consumed.
                    if (w_any) begin
                        r_hold           <= w_req_sel;
                        r_owner          <= w_grant;
                        r_state          <= S_ISSUE;
                        r_pcr_req_valid  <= 1'b1;
                        r_pcr_resp_ready <= 1'b0;
                        r_busy           <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.pcr_req_ready) begin
                        r_state          <= S_WAIT;
                        r_pcr_req_valid  <= 1'b0;
                        r_pcr_resp_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.pcr_resp_valid) begin
                        r_hold_resp      <= bus.pcr_resp_data;
                        r_state          <= S_DELIVER;
                        r_pcr_resp_ready <= 1'b0;
                        r_resp_valid     <= w_owner_oh;
                    end
                end
                S_DELIVER: begin
                    // The pointer moves only on completion, so a persistent requester waits at most N_REQ turns.
                    if (bus.resp_ready[r_owner]) begin
                        r_rr_ptr         <= IDX_W'(wrap_add(int'(r_owner), 1, N_REQ));
                        r_state          <= S_IDLE;
                        r_resp_valid     <= '0;
                        r_pcr_resp_ready <= 1'b1;
                        r_busy           <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated by reset so a request is never acknowledged on an edge that will not capture it.
    assign bus.req_ready      = (r_state == S_IDLE && w_any && !reset) ? w_grant_oh : '0;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_data      = r_hold_resp;
    assign bus.pcr_req_valid  = r_pcr_req_valid;
    assign bus.pcr_req_rw     = r_hold.rw;
    assign bus.pcr_req_addr   = r_hold.addr;
    assign bus.pcr_req_data   = r_hold.data;
    assign bus.pcr_resp_ready = r_pcr_resp_ready;
    assign busy               = r_busy;

endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
// Bench for vscale_htif_pcr_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level reference model.
module tb_vscale_htif_pcr_arbiter;
    import vscale_htif_pcr_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int AW = CSR_ADDR_WIDTH;
    localparam int DW = HTIF_PCR_WIDTH;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;

    vscale_htif_pcr_arbiter_if #(.N_REQ(N)) bus ();

    vscale_htif_pcr_arbiter #(.N_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    // First valid requester at or after ptr, wrapping; -1 when none.
    function automatic int model_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.req_valid[i]        = v;
        bus.req_rw[i]           = rw;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic idle_inputs();
        bus.req_valid      = '0;
        bus.req_rw         = '0;
        bus.req_addr       = '0;
        bus.req_data       = '0;
        bus.resp_ready     = '1;
        bus.pcr_req_ready  = 1'b1;
        bus.pcr_resp_valid = 1'b0;
        bus.pcr_resp_data  = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, " req_ready"}, bus.req_ready, '0);
        check({pfx, " resp_valid"}, bus.resp_valid, '0);
        check({pfx, " pcr_req_valid"}, bus.pcr_req_valid, 1'b0);
        check({pfx, " busy"}, busy, 1'b0);
        check({pfx, " pcr_req_rw"}, bus.pcr_req_rw, 1'b0);
        check({pfx, " pcr_req_addr"}, bus.pcr_req_addr, '0);
        check({pfx, " pcr_req_data"}, bus.pcr_req_data, '0);
        check({pfx, " resp_data"}, bus.resp_data, '0);
        check({pfx, " pcr_resp_ready"}, bus.pcr_resp_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int grants[$];
        bit pend_v[N];
        bit pend_rw[N];
        logic [AW-1:0] pend_a[N];
        logic [DW-1:0] pend_d[N];
        logic [N-1:0] vv;
        int m_ptr, m_stage, m_owner, done, g;
        pcr_req_t m_req;
        logic [DW-1:0] m_resp, csr_val;
        bit csr_has;

        // Reset values, with every requester asking during reset.
        idle_inputs();
        bus.req_valid = '1;
        reset = 1'b1;
        cyc();
        cyc();
        settle();
        check_reset_outputs("reset");

        // Single read: requester 0 reads 0x780, CSR returns 0x1234.
        do_reset();
        set_req(0, 1'b1, 1'b0, 12'h780, '0);
        settle();
        check("rd c0 req_ready", bus.req_ready, 3'b001);
        cyc();
        set_req(0, 1'b0, 1'b0, '0, '0);
        settle();
        check("rd c1 pcr_req_valid", bus.pcr_req_valid, 1'b1);
        check("rd c1 pcr_req_addr", bus.pcr_req_addr, 12'h780);
        check("rd c1 pcr_req_rw", bus.pcr_req_rw, 1'b0);
        cyc();
        bus.pcr_resp_valid = 1'b1;
        bus.pcr_resp_data  = 64'h1234;
        settle();
        check("rd c2 pcr_resp_ready", bus.pcr_resp_ready, 1'b1);
        check("rd c2 resp_valid", bus.resp_valid, '0);
        cyc();
        bus.pcr_resp_valid = 1'b0;
        settle();
        check("rd c3 resp_valid", bus.resp_valid, 3'b001);
        check("rd c3 resp_data", bus.resp_data, 64'h1234);
        cyc();
        settle();
        check("rd c4 busy", busy, 1'b0);
        check("rd c4 resp_valid", bus.resp_valid, '0);

        // Requesters 0 and 1 hold valid from reset; grants must alternate.
        do_reset();
        set_req(0, 1'b1, 1'b0, 12'h700, '0);
        set_req(1, 1'b1, 1'b0, 12'h701, '0);
        bus.pcr_resp_valid = 1'b1;
        bus.pcr_resp_data  = 64'hA5;
        m_owner = -1;
        for (int c = 0; c < 60 && grants.size() < 4; c++) begin
            settle();
            check("alt req_ready onehot0", $onehot0(bus.req_ready), 1'b1);
            if (bus.resp_valid != '0) check("alt resp owner", bus.resp_valid, oh(m_owner));
            for (int i = 0; i < N; i++) if (bus.req_ready[i]) begin
                grants.push_back(i);
                m_owner = i;
            end
            cyc();
        end
        check("alt grant count", grants.size(), 4);
        for (int k = 0; k < grants.size(); k++) check("alt grant order", grants[k], k % 2);
        idle_inputs();
        for (int c = 0; c < 10 && busy; c++) cyc();

        // Back-pressure on both the CSR request and the requester response.
        do_reset();
        set_req(0, 1'b1, 1'b1, 12'h7A5, 64'h55AA_0000_1111_2222);
        bus.pcr_req_ready = 1'b0;
        settle();
        check("bp req_ready", bus.req_ready, 3'b001);
        cyc();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b1, 1'b0, 12'h123, 64'h77);
        for (int j = 0; j < 6; j++) begin
            if (j == 5) bus.pcr_req_ready = 1'b1;
            settle();
            check("bp pcr_req_valid", bus.pcr_req_valid, 1'b1);
            check("bp pcr_req_addr", bus.pcr_req_addr, 12'h7A5);
            check("bp pcr_req_data", bus.pcr_req_data, 64'h55AA_0000_1111_2222);
            check("bp no second grant", bus.req_ready, '0);
            cyc();
        end
        bus.pcr_resp_valid = 1'b1;
        bus.pcr_resp_data  = 64'hBEEF;
        bus.resp_ready[0]  = 1'b0;
        cyc();
        bus.pcr_resp_valid = 1'b0;
        bus.pcr_resp_data  = 64'h0BAD;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) bus.resp_ready[0] = 1'b1;
            settle();
            check("bp resp_valid", bus.resp_valid, 3'b001);
            check("bp resp_data", bus.resp_data, 64'hBEEF);
            cyc();
        end
        settle();
        check("bp next grant rr", bus.req_ready, 3'b010);

        // Write: requester 1 writes 0xDEAD to 0x781.
        do_reset();
        set_req(1, 1'b1, 1'b1, 12'h781, 64'hDEAD);
        settle();
        check("wr req_ready", bus.req_ready, 3'b010);
        cyc();
        set_req(1, 1'b0, 1'b0, '0, '0);
        settle();
        check("wr pcr_req_valid", bus.pcr_req_valid, 1'b1);
        check("wr pcr_req_rw", bus.pcr_req_rw, 1'b1);
        check("wr pcr_req_addr", bus.pcr_req_addr, 12'h781);
        check("wr pcr_req_data", bus.pcr_req_data, 64'hDEAD);
        cyc();
        bus.pcr_resp_valid = 1'b1;
        settle();
        check("wr early resp_valid", bus.resp_valid, '0);
        cyc();
        bus.pcr_resp_valid = 1'b0;
        settle();
        check("wr resp_valid", bus.resp_valid, 3'b010);
        cyc();

        // Reset while waiting for the CSR, then a stale response.
        do_reset();
        set_req(1, 1'b1, 1'b0, 12'h7C0, '0);
        cyc();
        set_req(1, 1'b0, 1'b0, '0, '0);
        cyc();
        settle();
        check("rst wait busy", busy, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.pcr_resp_valid = 1'b1;
        bus.pcr_resp_data  = 64'h999;
        settle();
        check_reset_outputs("rst mid");
        cyc();
        bus.pcr_resp_valid = 1'b0;
        settle();
        check("rst stale resp_valid", bus.resp_valid, '0);
        check("rst stale busy", busy, 1'b0);
        set_req(0, 1'b1, 1'b0, 12'h010, '0);
        set_req(1, 1'b1, 1'b0, 12'h011, '0);
        settle();
        check("rst next grant", bus.req_ready, 3'b001);

        // Randomized traffic against a transaction-level model.
        do_reset();
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        m_ptr = 0; m_stage = 0; m_owner = 0; done = 0; csr_has = 1'b0;
        m_req = '0; m_resp = '0; csr_val = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(2) == 0) begin
                    pend_v[i]  = 1'b1;
                    pend_rw[i] = 1'($urandom_range(1));
                    pend_a[i]  = AW'($urandom);
                    pend_d[i]  = {$urandom, $urandom};
                end
                set_req(i, pend_v[i], pend_rw[i], pend_a[i], pend_d[i]);
                vv[i] = pend_v[i];
                bus.resp_ready[i] = ($urandom_range(3) != 0);
            end
            bus.pcr_req_ready  = 1'($urandom_range(1));
            bus.pcr_resp_valid = (csr_has && $urandom_range(1) == 1) ||
                                 (m_stage == 0 && $urandom_range(7) == 0);
            bus.pcr_resp_data  = csr_has ? csr_val : {$urandom, $urandom};
            settle();
            g = (m_stage == 0) ? model_pick(vv, m_ptr) : -1;
            check("rnd req_ready", bus.req_ready, oh(g));
            check("rnd busy", busy, m_stage != 0);
            check("rnd pcr_req_valid", bus.pcr_req_valid, m_stage == 1);
            check("rnd pcr_resp_ready", bus.pcr_resp_ready, m_stage == 0 || m_stage == 2);
            check("rnd resp_valid", bus.resp_valid, (m_stage == 3) ? oh(m_owner) : '0);
            if (m_stage == 1) begin
                check("rnd pcr_req_rw", bus.pcr_req_rw, m_req.rw);
                check("rnd pcr_req_addr", bus.pcr_req_addr, m_req.addr);
                check("rnd pcr_req_data", bus.pcr_req_data, m_req.data);
            end
            if (m_stage == 3) check("rnd resp_data", bus.resp_data, m_resp);
            case (m_stage)
                0: if (g >= 0) begin
                    m_owner = g;
                    m_req   = '{rw: pend_rw[g], addr: pend_a[g], data: pend_d[g]};
                    pend_v[g] = 1'b0;
                    m_stage = 1;
                end
                1: if (bus.pcr_req_ready) begin
                    m_stage = 2;
                    csr_has = 1'b1;
                    csr_val = {$urandom, $urandom};
                end
                2: if (bus.pcr_resp_valid) begin
                    m_resp  = bus.pcr_resp_data;
                    csr_has = 1'b0;
                    m_stage = 3;
                end
                default: if (bus.resp_ready[m_owner]) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_stage = 0;
                    done++;
                end
            endcase
            cyc();
        end
        check("rnd completions >= 100", done >= 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vscale_htif_pcr_arbiter.md
# vscale_htif_pcr_arbiter

Shares the CSR file's single HTIF PCR request/response channel among `N_REQ` host-side requesters, for example a host link and a debug bridge. It sits between the requesters and the CSR file's `htif_pcr_*` ports. It grants one requester at a time using round-robin order, registers that request, issues it to the CSR file, and routes the response back to the owning requester. At most one transaction is outstanding.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `IDX_W`, default `$clog2(N_REQ)` (min 1): owner/pointer width (derived).
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, `N_REQ`: per-requester request valid.
- `req_ready`, out, `N_REQ`: per-requester request accept. One-hot or zero.
- `req_rw`, in, `N_REQ`: per-requester write flag (1 = write).
- `req_addr`, in, `N_REQ*CSR_ADDR_WIDTH`: flattened addresses. Requester i occupies slice `[i*12 +: 12]`.
- `req_data`, in, `N_REQ*HTIF_PCR_WIDTH`: flattened write data. Requester i occupies slice `[i*64 +: 64]`.
- `resp_valid`, out, `N_REQ`: per-requester response valid. One-hot or zero.
- `resp_ready`, in, `N_REQ`: per-requester response accept.
- `resp_data`, out, `HTIF_PCR_WIDTH`: shared response data. Valid only for the requester whose `resp_valid` is high.
- `pcr_req_valid`, out, 1: request valid to the CSR file.
- `pcr_req_ready`, in, 1: request ready from the CSR file.
- `pcr_req_rw`, out, 1: write flag to the CSR file.
- `pcr_req_addr`, out, `CSR_ADDR_WIDTH`: address to the CSR file.
- `pcr_req_data`, out, `HTIF_PCR_WIDTH`: write data to the CSR file.
- `pcr_resp_valid`, in, 1: response valid from the CSR file.
- `pcr_resp_ready`, out, 1: response accept to the CSR file.
- `pcr_resp_data`, in, `HTIF_PCR_WIDTH`: response data from the CSR file.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- Registered state: `state`, `owner[IDX_W]`, `rr_ptr[IDX_W]`, `hold_rw`, `hold_addr`, `hold_data`, `hold_resp`.
- Grant function: the first `i` with `req_valid[i]` high, searching from `rr_ptr` upward modulo `N_REQ`.
- IDLE:
  - If any `req_valid` is high, assert `req_ready[g]` for the granted requester only, combinationally.
  - On that edge, capture `rw`, `addr` and `data` into the hold registers, set `owner <= g`, and go to ISSUE.
  - In IDLE, `pcr_resp_ready` = 1. Any `pcr_resp_valid` seen here is stale and is discarded with no state change.
- ISSUE:
  - `pcr_req_valid` = 1. The `pcr_req_*` outputs are driven from the hold registers and stay stable until accepted.
  - On `pcr_req_ready`, go to WAIT.
- WAIT:
  - `pcr_resp_ready` = 1.
  - On `pcr_resp_valid`, capture `hold_resp <= pcr_resp_data` and go to DELIVER.
- DELIVER:
  - `resp_valid[owner]` = 1 and `resp_data` = `hold_resp`.
  - On `resp_ready[owner]`, set `rr_ptr <= (owner == N_REQ-1) ? 0 : owner+1` and go to IDLE.
- Reads and writes follow the same sequence. A write still waits for and delivers the CSR file's response.
- `rr_ptr` changes only on response completion. A requester that keeps `req_valid` high is therefore served within `N_REQ` transactions.
- Responses to requesters other than `owner` are never asserted. A `resp_ready` from a non-owner is ignored.
- Reset, including mid-transaction:
  - `state` = IDLE, `rr_ptr` = 0, `owner` = 0, all hold registers = 0.
  - Any in-flight transaction is abandoned.
  - The CSR file's HTIF side must be reset in the same cycle. If it is not, its late response is flushed by the IDLE discard rule.

## Timing
- Reset values of outputs:
  - `req_ready` = 0, `resp_valid` = 0, `pcr_req_valid` = 0, `busy` = 0.
  - `pcr_req_rw` = 0, `pcr_req_addr` = 0, `pcr_req_data` = 0, `resp_data` = 0.
  - `pcr_resp_ready` = 1, because IDLE is the reset state.
- Outputs are functions of the registered state only, except `req_ready`, which also depends on `req_valid`.
- Best-case latency with the CSR file idle and the requester always ready:
  - Cycle 0: request accepted.
  - Cycle 1: `pcr_req_valid`, accepted the same cycle.
  - Cycle 2: `pcr_resp_valid`, captured.
  - Cycle 3: `resp_valid`, accepted.
  - Cycle 4: IDLE again. Throughput is one transaction per 4 cycles.
- Back-pressure on any handshake holds the current state indefinitely. There is no timeout.
- Simultaneous requests at IDLE: exactly one grant per cycle. All others see `req_ready` = 0.

## Structure
- `CSR_ADDR_WIDTH` (12) and `HTIF_PCR_WIDTH` (64) come from the existing shared control/CSR headers.
- The arbiter state encodings (IDLE=0, ISSUE=1, WAIT=2, DELIVER=3) are added as localparams in `vscale_ctrl_constants.vh`.
- One sub-module is natural: `vscale_rr_pick`, a combinational round-robin priority picker with inputs `valid[N_REQ]` and `ptr`, and outputs `any` and `idx`.
- The FSM, hold registers and routing stay in the top module.

## Test plan
- Single read: requester 0 reads address 0x780; the CSR model returns 0x1234.
  - Required: `pcr_req_valid` at cycle 1, and `resp_valid[0]` with `resp_data` = 0x1234 at cycle 3.
- Simultaneous requests: both requesters assert `req_valid` from reset and hold it.
  - Required: grants alternate 0, 1, 0, 1, and `resp_valid` is never asserted for the wrong owner.
- Back-pressure:
  - CSR model holds `pcr_req_ready` = 0 for 5 cycles: `pcr_req_addr`/`pcr_req_data` stay stable and no second grant occurs.
  - Requester holds `resp_ready` = 0 for 3 cycles: `resp_data` stays constant.
- Write: requester 1 writes 0xDEAD to address 0x781.
  - Required: `pcr_req_rw` = 1, `pcr_req_data` = 0xDEAD, and `resp_valid[1]` is delivered after the CSR response.
- Reset in WAIT: assert `reset` for one cycle, then present a stale `pcr_resp_valid`.
  - Required: outputs return to reset values, the stale response is consumed (`pcr_resp_ready` = 1), no `resp_valid` is asserted, and the next request is granted to requester 0.
